// File: rtl/pacman_mover_if.sv
// Draw handshake between the Pac-Man mover and the 5x5 sprite drawer.
// The mover owns go and the sprite description; the drawer answers with busy.
interface pacman_mover_if;
   logic        go;
   logic        busy;
   logic [7:0]  x_out;
   logic [6:0]  y_out;
   logic [24:0] shape;

   modport master (
      output go,
      output x_out,
      output y_out,
      output shape,
      input  busy
   );

   modport slave (
      input  go,
      input  x_out,
      input  y_out,
      input  shape,
      output busy
   );
endinterface

// File: rtl/pacman_mover.sv
// Pac-Man tile mover: on each rate tick, steps one tile in the latched direction,
// animates the mouth, and hands the new sprite to the 5x5 drawer over a go/busy handshake.
// Macro PACMAN_WRAP_EN: when defined, moves off an edge wrap to the opposite edge;
// otherwise they are refused and flagged on blocked.
module pacman_mover #(
   parameter logic [7:0] X_MAX   = 8'd31,
   parameter logic [6:0] Y_MAX   = 7'd23,
   parameter logic [7:0] START_X = 8'd15,
   parameter logic [6:0] START_Y = 7'd11
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          tick,
   input  logic [2:0]    dir_in,
   output logic          blocked,
   pacman_mover_if.master draw
);

   // Row-major 5x5 bitmaps, bit 24 = row 0 col 0.
   localparam logic [24:0] SHAPE_CLOSED = 25'h0EFFFEE;
   localparam logic [24:0] SHAPE_RIGHT  = 25'h0EF73CE;  // 01110 11110 11100 11110 01110
   localparam logic [24:0] SHAPE_LEFT   = 25'h0E79DEE;  // right, mirrored left/right
   localparam logic [24:0] SHAPE_DOWN   = 25'h0EFFF60;  // right, transposed
   localparam logic [24:0] SHAPE_UP     = 25'h00DFFEE;  // down, mirrored top/bottom

   typedef enum logic [2:0] {
      StIdle,
      StStep,
      StIssue,
      StWaitAck,
      StWaitDone
   } state_e;

   state_e      state_q;
   logic        pending_q;
   logic [2:0]  dir_q;
   logic        go_q;
   logic [7:0]  x_q;
   logic [6:0]  y_q;
   logic        frame_q;
   logic [24:0] shape_q;
   logic        blocked_q;

   logic [7:0]  x_next;
   logic [6:0]  y_next;
   logic        block_next;
   logic [24:0] open_shape;

   // Candidate position for the latched direction; edge test happens before any add/subtract.
   always_comb begin
      x_next     = x_q;
      y_next     = y_q;
      block_next = 1'b0;
      unique case (dir_q[1:0])
         2'b00: begin
            if (x_q == X_MAX) begin
`ifdef PACMAN_WRAP_EN
               x_next = 8'd0;
`else
               block_next = 1'b1;
`endif
            end else begin
               x_next = x_q + 8'd1;
            end
         end
         2'b01: begin
            if (x_q == 8'd0) begin
`ifdef PACMAN_WRAP_EN
               x_next = X_MAX;
`else
               block_next = 1'b1;
`endif
            end else begin
               x_next = x_q - 8'd1;
            end
         end
         2'b10: begin
            if (y_q == 7'd0) begin
`ifdef PACMAN_WRAP_EN
               y_next = Y_MAX;
`else
               block_next = 1'b1;
`endif
            end else begin
               y_next = y_q - 7'd1;
            end
         end
         2'b11: begin
            if (y_q == Y_MAX) begin
`ifdef PACMAN_WRAP_EN
               y_next = 7'd0;
`else
               block_next = 1'b1;
`endif
            end else begin
               y_next = y_q + 7'd1;
            end
         end
         default: ;
      endcase
   end

   // Open-mouth bitmap facing the latched direction.
   always_comb begin
      open_shape = SHAPE_RIGHT;
      unique case (dir_q[1:0])
         2'b00:   open_shape = SHAPE_RIGHT;
         2'b01:   open_shape = SHAPE_LEFT;
         2'b10:   open_shape = SHAPE_UP;
         2'b11:   open_shape = SHAPE_DOWN;
         default: open_shape = SHAPE_RIGHT;
      endcase
   end

   // Move/draw sequencer with one-deep tick buffering; all outputs registered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         pending_q <= 1'b0;
         dir_q     <= 3'b000;
         go_q      <= 1'b0;
         x_q       <= START_X;
         y_q       <= START_Y;
         frame_q   <= 1'b0;
         shape_q   <= SHAPE_CLOSED;
         blocked_q <= 1'b0;
      end else begin
         go_q <= 1'b0;
         if (state_q != StIdle && tick) begin
            pending_q <= 1'b1;
         end
         case (state_q)
            StIdle: begin
               if (tick || pending_q) begin
                  dir_q <= dir_in;
                  // A tick landing on the cycle the pending one is consumed re-arms it.
                  pending_q <= pending_q && tick;
                  state_q   <= StStep;
               end
            end
            StStep: begin
               if (dir_q[2]) begin
                  x_q       <= x_next;
                  y_q       <= y_next;
                  blocked_q <= block_next;
                  frame_q   <= ~frame_q;
                  // Frame flips, so the new sprite is open when the old frame was closed.
                  shape_q   <= frame_q ? SHAPE_CLOSED : open_shape;
               end else begin
                  blocked_q <= 1'b0;
               end
               state_q <= StIssue;
            end
            StIssue: begin
               if (!draw.busy) begin
                  go_q    <= 1'b1;
                  state_q <= StWaitAck;
               end
            end
            StWaitAck: begin
               if (draw.busy) begin
                  state_q <= StWaitDone;
               end
            end
            StWaitDone: begin
               if (!draw.busy) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign draw.go    = go_q;
   assign draw.x_out = x_q;
   assign draw.y_out = y_q;
   assign draw.shape = shape_q;
   assign blocked    = blocked_q;

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover: table of single moves plus hand-written
// busy-hold, tick-buffering, edge and mid-handshake reset sequences.
module tb_pacman_mover;

   localparam logic [24:0] SHAPE_CLOSED = 25'h0EFFFEE;
   localparam logic [24:0] SHAPE_RIGHT  = 25'h0EF73CE;
   localparam logic [24:0] SHAPE_LEFT   = 25'h0E79DEE;
   localparam logic [24:0] SHAPE_DOWN   = 25'h0EFFF60;
   localparam logic [24:0] SHAPE_UP     = 25'h00DFFEE;
`ifdef PACMAN_WRAP_EN
   localparam int Wrap = 1;
`else
   localparam int Wrap = 0;
`endif

   typedef struct packed {
      logic [2:0]  dir;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [24:0] shape;
      logic        blk;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       tick;
   logic [2:0] dir_in;
   logic       blocked;
   int         total = 0;
   int         bad = 0;

   pacman_mover_if draw_if ();

   pacman_mover dut (
      .clock   (clock),
      .reset   (reset),
      .tick    (tick),
      .dir_in  (dir_in),
      .blocked (blocked),
      .draw    (draw_if)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Returns cycles from the tick edge until go is seen, -1 if it never comes.
   task automatic wait_go(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (draw_if.go === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_move(input logic [2:0] d, output int lat, output logic [7:0] cx,
                          output logic [6:0] cy, output logic [24:0] cs, output logic cb);
      dir_in = d;
      tick   = 1'b1;
      step();
      tick = 1'b0;
      wait_go(lat);
      cx = draw_if.x_out;
      cy = draw_if.y_out;
      cs = draw_if.shape;
      cb = blocked;
      draw_if.busy = 1'b1;
      step();
      chk("go_one_cycle", 32'(draw_if.go), 0);
      step();
      step();
      draw_if.busy = 1'b0;
      step();
      step();
   endtask

   // Drawer model: answers each go with busy for three cycles; counts gos.
   task automatic run_drawer(input int cycles, output int gos);
      int cnt;
      cnt = 0;
      gos = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (draw_if.go === 1'b1) begin
            gos++;
            draw_if.busy = 1'b1;
            cnt = 3;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) draw_if.busy = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   vec_t        vecs [8];
   int          lat;
   int          gos;
   logic [7:0]  cx;
   logic [6:0]  cy;
   logic [24:0] cs;
   logic        cb;

   initial begin
      // dir, x, y, shape, blocked after the move (from reset at 15,11)
      vecs[0] = '{3'b100, 8'd16, 7'd11, SHAPE_RIGHT,  1'b0};
      vecs[1] = '{3'b110, 8'd16, 7'd10, SHAPE_CLOSED, 1'b0};
      vecs[2] = '{3'b111, 8'd16, 7'd11, SHAPE_DOWN,   1'b0};
      vecs[3] = '{3'b101, 8'd15, 7'd11, SHAPE_CLOSED, 1'b0};
      vecs[4] = '{3'b101, 8'd14, 7'd11, SHAPE_LEFT,   1'b0};
      vecs[5] = '{3'b010, 8'd14, 7'd11, SHAPE_LEFT,   1'b0};
      vecs[6] = '{3'b110, 8'd14, 7'd10, SHAPE_CLOSED, 1'b0};
      vecs[7] = '{3'b110, 8'd14, 7'd9,  SHAPE_UP,     1'b0};

      reset        = 1'b1;
      tick         = 1'b0;
      dir_in       = 3'b000;
      draw_if.busy = 1'b0;
      #3;
      chk("rst_go", 32'(draw_if.go), 0);
      chk("rst_x", 32'(draw_if.x_out), 15);
      chk("rst_y", 32'(draw_if.y_out), 11);
      chk("rst_shape", 32'(draw_if.shape), 32'(SHAPE_CLOSED));
      chk("rst_blocked", 32'(blocked), 0);
      step();
      step();
      reset = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         do_move(vecs[i].dir, lat, cx, cy, cs, cb);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 2);
         chk($sformatf("vec%0d_x", i), 32'(cx), 32'(vecs[i].x));
         chk($sformatf("vec%0d_y", i), 32'(cy), 32'(vecs[i].y));
         chk($sformatf("vec%0d_shape", i), 32'(cs), 32'(vecs[i].shape));
         chk($sformatf("vec%0d_blocked", i), 32'(cb), 32'(vecs[i].blk));
      end

      // Drawer busy for the whole ISSUE phase: no go until busy falls.
      draw_if.busy = 1'b1;
      dir_in       = 3'b100;
      tick         = 1'b1;
      step();
      tick = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("hold_go_low", 32'(draw_if.go), 0);
      end
      chk("hold_x", 32'(draw_if.x_out), 15);
      draw_if.busy = 1'b0;
      step();
      chk("hold_go_after_release", 32'(draw_if.go), 1);
      chk("hold_x_at_go", 32'(draw_if.x_out), 15);
      draw_if.busy = 1'b1;
      step();
      step();
      draw_if.busy = 1'b0;
      step();
      step();

      // Three ticks while the drawer works collapse into one extra move.
      dir_in = 3'b100;
      tick   = 1'b1;
      step();
      tick = 1'b0;
      wait_go(lat);
      draw_if.busy = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         step();
      end
      draw_if.busy = 1'b0;
      run_drawer(40, gos);
      chk("pending_extra_gos", 32'(gos), 1);
      chk("pending_x", 32'(draw_if.x_out), 17);

      // Tick on the very cycle IDLE consumes the pending tick re-arms it.
      dir_in = 3'b100;
      tick   = 1'b1;
      step();
      tick = 1'b0;
      wait_go(lat);
      draw_if.busy = 1'b1;
      step();
      tick = 1'b1;
      step();
      tick         = 1'b0;
      draw_if.busy = 1'b0;
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      run_drawer(60, gos);
      chk("rearm_gos", 32'(gos), 2);
      chk("rearm_x", 32'(draw_if.x_out), 20);

      // Edges: walk to x=0 and y=Y_MAX, then push past them.
      do_reset();
      for (int i = 0; i < 15; i++) do_move(3'b101, lat, cx, cy, cs, cb);
      chk("x_at_left_edge", 32'(cx), 0);
      do_move(3'b101, lat, cx, cy, cs, cb);
      chk("left_edge_x", 32'(cx), Wrap != 0 ? 31 : 0);
      chk("left_edge_blocked", 32'(cb), Wrap != 0 ? 0 : 1);
      chk("left_edge_shape", 32'(cs), 32'(SHAPE_CLOSED));
      for (int i = 0; i < 12; i++) do_move(3'b111, lat, cx, cy, cs, cb);
      chk("y_at_bottom", 32'(cy), 23);
      do_move(3'b111, lat, cx, cy, cs, cb);
      chk("bottom_edge_y", 32'(cy), Wrap != 0 ? 0 : 23);
      chk("bottom_edge_blocked", 32'(cb), Wrap != 0 ? 0 : 1);
      chk("bottom_edge_shape", 32'(cs), 32'(SHAPE_DOWN));
      do_move(3'b011, lat, cx, cy, cs, cb);
      chk("still_latency", 32'(lat), 2);
      chk("still_blocked", 32'(cb), 0);
      chk("still_y", 32'(cy), Wrap != 0 ? 0 : 23);
      chk("still_shape", 32'(cs), 32'(SHAPE_DOWN));

      // Reset during the handshake takes effect without waiting for a clock.
      do_reset();
      dir_in = 3'b100;
      tick   = 1'b1;
      step();
      tick = 1'b0;
      wait_go(lat);
      chk("pre_reset_go", 32'(draw_if.go), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_go", 32'(draw_if.go), 0);
      chk("async_rst_x", 32'(draw_if.x_out), 15);
      chk("async_rst_shape", 32'(draw_if.shape), 32'(SHAPE_CLOSED));
      step();
      reset = 1'b0;
      gos   = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 2) draw_if.busy = 1'b1;
         if (i == 5) draw_if.busy = 1'b0;
         step();
         if (draw_if.go === 1'b1) gos++;
      end
      chk("no_go_after_reset", 32'(gos), 0);
      do_move(3'b100, lat, cx, cy, cs, cb);
      chk("post_reset_latency", 32'(lat), 2);
      chk("post_reset_x", 32'(cx), 16);
      chk("post_reset_shape", 32'(cs), 32'(SHAPE_RIGHT));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
